// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between a load/store initiator and mem_responder.
// The initiator uses the master modport, the responder the slave modport.
interface mem_responder_if #(
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [63:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Handshaked single-outstanding data-memory responder with fixed wait states.
// Define MEM_RESPONDER_ERR_EN to flag (and suppress) accesses at or above DEPTH.
module mem_responder #(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    mem_responder_if.slave bus
);
    localparam int          IDX_W    = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_write;
    logic [63:0]         r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [IDX_W-1:0]    w_idx;
    logic                w_addr_oor;
    logic                w_err;

    assign w_idx      = r_addr[IDX_W-1:0];
    assign w_addr_oor = |r_addr[63:IDX_W];

`ifdef MEM_RESPONDER_ERR_EN
    assign w_err = w_addr_oor;
`else
    logic w_unused_addr;
    assign w_unused_addr = w_addr_oor;
    assign w_err         = 1'b0;
`endif

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

    // The counter is loaded with LATENCY and the access happens on the edge after it
    // reaches zero, so RSP_VALID rises LATENCY+1 edges after the accept edge.
    // NOTE: every register here, state and memory alike, uses non-blocking assignment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            // NOTE: the memory array is cleared by reset, so it maps to flops, not a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_write     <= bus.req_write;
                        r_addr      <= bus.req_addr;
                        r_wdata     <= bus.req_wdata;
                        r_cnt       <= CNT_INIT;
                        r_req_ready <= 1'b0;
                        r_state     <= S_WAIT;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        if (r_write) begin
                            if (!w_err) begin
                                r_mem[w_idx] <= r_wdata;
                            end
                            r_rsp_rdata <= '0;
                        end else begin
                            r_rsp_rdata <= w_err ? '0 : r_mem[w_idx];
                        end
                        r_rsp_err   <= w_err;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Directed, table-driven bench for mem_responder: reset, read/write, wrap/error,
// backpressure, ignored inputs and reset in the middle of a write.
module tb_mem_responder;
    localparam int DATA_W  = 64;
    localparam int DEPTH   = 32;
    localparam int LATENCY = 2;
`ifdef MEM_RESPONDER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if #(.DATA_W(DATA_W)) bus ();

    mem_responder #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic start_req(input logic wr, input logic [63:0] addr, input logic [63:0] wdata);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        for (int k = 0; k < 20; k++) begin
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept_seen", 64'(ok), 64'd1);
        if (ok) begin
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic do_txn(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                          output logic [63:0] rdata, output logic err, output int lat);
        start_req(wr, addr, wdata);
        wait_rsp(lat);
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        if (lat > 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;
        bit          seen;

        vecs[0]  = '{1'b0, 64'd5,  64'd0,           64'd0,                         1'b0};
        vecs[1]  = '{1'b1, 64'd2,  64'h1234,        64'd0,                         1'b0};
        vecs[2]  = '{1'b0, 64'd2,  64'd0,           64'h1234,                      1'b0};
        vecs[3]  = '{1'b1, 64'd31, 64'hDEAD_BEEF,   64'd0,                         1'b0};
        vecs[4]  = '{1'b0, 64'd31, 64'd0,           64'hDEAD_BEEF,                 1'b0};
        vecs[5]  = '{1'b1, 64'd0,  64'h5555,        64'd0,                         1'b0};
        vecs[6]  = '{1'b0, 64'd0,  64'd0,           64'h5555,                      1'b0};
        vecs[7]  = '{1'b1, 64'd40, 64'hFFFF,        64'd0,                         ERR_EN};
        vecs[8]  = '{1'b0, 64'd8,  64'd0,           ERR_EN ? 64'd0 : 64'hFFFF,     1'b0};
        vecs[9]  = '{1'b0, 64'd40, 64'd0,           ERR_EN ? 64'd0 : 64'hFFFF,     ERR_EN};
        vecs[10] = '{1'b0, 64'd33, 64'd0,           64'd0,                         ERR_EN};

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;

        // Reset held for three cycles, outputs quiet throughout.
        repeat (3) begin
            @(negedge clk);
            check("rst_req_ready", bus.req_ready, 1'b0);
            check("rst_rsp_valid", bus.rsp_valid, 1'b0);
            check("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
            check("rst_rsp_err",   bus.rsp_err,   1'b0);
        end
        rst_n = 1'b1;
        #1;
        check("release_req_ready_low", bus.req_ready, 1'b0);
        @(posedge clk);
        #1;
        check("release_req_ready_high", bus.req_ready, 1'b1);

        // Table: reset read, write/read pairs, boundary words, out-of-range handling.
        for (int i = 0; i < NV; i++) begin
            do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_err", i), er, vecs[i].exp_err);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(LATENCY + 1));
        end

        // Backpressure on a read of word 2.
        bus.rsp_ready = 1'b0;
        start_req(1'b0, 64'd2, 64'd0);
        wait_rsp(lat);
        check("bp_latency", 64'(lat), 64'(LATENCY + 1));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_valid_c%0d", c), bus.rsp_valid, 1'b1);
            check($sformatf("bp_rdata_c%0d", c), bus.rsp_rdata, 64'h1234);
            check($sformatf("bp_req_ready_c%0d", c), bus.req_ready, 1'b0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_valid_after_hs", bus.rsp_valid, 1'b0);
        check("bp_req_ready_after_hs", bus.req_ready, 1'b1);

        // Request inputs change after acceptance, and REQ_VALID is held through RESP.
        start_req(1'b1, 64'd4, 64'h77);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 64'd6;
        bus.req_wdata = 64'h99;
        wait_rsp(lat);
        check("ign_latency", 64'(lat), 64'(LATENCY + 1));
        check("ign_rdata", bus.rsp_rdata, 64'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.rsp_valid || !bus.req_ready) seen = 1'b1;
        end
        check("ign_no_extra_txn", 64'(seen), 64'd0);
        do_txn(1'b0, 64'd4, 64'd0, rd, er, lat);
        check("ign_read4", rd, 64'h77);
        do_txn(1'b0, 64'd6, 64'd0, rd, er, lat);
        check("ign_read6", rd, 64'd0);

        // Reset while a write of word 3 is waiting.
        start_req(1'b1, 64'd3, 64'hAAAA);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", bus.req_ready, 1'b0);
        check("midrst_rsp_valid", bus.rsp_valid, 1'b0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        check("midrst_no_rsp", 64'(seen), 64'd0);
        do_txn(1'b0, 64'd3, 64'd0, rd, er, lat);
        check("midrst_read3", rd, 64'd0);
        check("midrst_read3_latency", 64'(lat), 64'(LATENCY + 1));
        do_txn(1'b0, 64'd2, 64'd0, rd, er, lat);
        check("midrst_mem_cleared", rd, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
